// File: rtl/branch_predict_unit_pkg.sv
// ============================================================================
// Module  : branch_predict_unit_pkg
// Brief   : Branch funct3 codes, 2-bit counter states and the counter update rule.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_predict_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic taken;
    logic legal;
  } cond_t;

  // Saturating step of one BHT counter.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'b01;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
// ============================================================================
// Module  : branch_predict_unit_if
// Brief   : IF/EX branch-unit signal bundle; stats outputs exist with BPU_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
);
  logic             if_valid;
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic [IDX_W-1:0] if_pred_idx;
  logic             ex_valid;
  logic             ex_branch;
  logic [2:0]       ex_funct3;
  logic             ex_pred_taken;
  logic [IDX_W-1:0] ex_pred_idx;
  logic             zf;
  logic             vf;
  logic             sf;
  logic             cf;
  logic             ex_taken;
  logic             ex_mispredict;
`ifdef BPU_STATS_EN
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispred;
`endif

  modport master (
    output if_valid, if_pc, ex_valid, ex_branch, ex_funct3, ex_pred_taken,
           ex_pred_idx, zf, vf, sf, cf,
    input  if_pred_taken, if_pred_idx, ex_taken, ex_mispredict
`ifdef BPU_STATS_EN
    , input stat_branches, stat_mispred
`endif
  );

  modport slave (
    input  if_valid, if_pc, ex_valid, ex_branch, ex_funct3, ex_pred_taken,
           ex_pred_idx, zf, vf, sf, cf,
    output if_pred_taken, if_pred_idx, ex_taken, ex_mispredict
`ifdef BPU_STATS_EN
    , output stat_branches, stat_mispred
`endif
  );
endinterface

`default_nettype wire

// File: rtl/branch_predict_unit_br_cond_eval.sv
// ============================================================================
// Module  : br_cond_eval
// Brief   : Combinational branch condition from rs1-rs2 flags and funct3.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module br_cond_eval
  import branch_predict_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zf,
  input  logic       vf,
  input  logic       sf,
  input  logic       cf,
  output cond_t      cond
);

  always_comb begin
    cond = '{taken: 1'b0, legal: 1'b1};
    case (funct3)
      BR_BEQ:  cond.taken = zf;
      BR_BNE:  cond.taken = ~zf;
      BR_BLT:  cond.taken = sf ^ vf;
      BR_BGE:  cond.taken = ~(sf ^ vf);
      BR_BLTU: cond.taken = ~cf;
      BR_BGEU: cond.taken = cf;
      default: cond.legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module  : branch_predict_unit
// Brief   : 2-bit BHT predictor (bimodal or gshare) with EX-stage resolve/train.
//           Define BPU_STATS_EN to add branch / mispredict counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         BHT_ENTRIES = 64,
  parameter int         XLEN        = 32,
  parameter int         GSHARE      = 0,
  parameter logic [1:0] CTR_INIT    = CTR_WNT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_unit_if.slave bpu
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       r_bht [BHT_ENTRIES];
  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_ghr;
  logic [IDX_W-1:0] w_rd_idx;
  cond_t            w_cond;
  logic             w_live;
  logic             w_commit;
  logic             w_taken;
  logic             w_mispredict;
  logic             w_unused_pc;

  br_cond_eval u_cond (
    .funct3 (bpu.ex_funct3),
    .zf     (bpu.zf),
    .vf     (bpu.vf),
    .sf     (bpu.sf),
    .cf     (bpu.cf),
    .cond   (w_cond)
  );

  assign w_live       = bpu.ex_valid & bpu.ex_branch;
  assign w_commit     = w_live & w_cond.legal;
  assign w_taken      = w_commit & w_cond.taken;
  assign w_mispredict = w_commit & (w_cond.taken != bpu.ex_pred_taken);

  assign bpu.ex_taken      = w_taken;
  assign bpu.ex_mispredict = w_mispredict;

  assign w_pc_idx    = bpu.if_pc[IDX_W+1:2];
  assign w_unused_pc = ^{bpu.if_pc[XLEN-1:IDX_W+2], bpu.if_pc[1:0]};

  generate
    if (GSHARE != 0) begin : g_gshare
      logic [IDX_W-1:0] r_ghr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_ghr <= '0;
        else if (w_commit) r_ghr <= {r_ghr[IDX_W-2:0], w_taken};
      end
      assign w_ghr = r_ghr;
    end else begin : g_bimodal
      assign w_ghr = '0;
    end
  endgenerate

  // Read sees the pre-update counter when EX trains the same entry.
  assign w_rd_idx          = w_pc_idx ^ w_ghr;
  assign bpu.if_pred_idx   = w_rd_idx;
  assign bpu.if_pred_taken = bpu.if_valid & r_bht[w_rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_INIT;
    end else if (w_commit) begin
      r_bht[bpu.ex_pred_idx] <= ctr_update(r_bht[bpu.ex_pred_idx], w_cond.taken);
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_commit && (r_stat_branches != '1))
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict && (r_stat_mispred != '1))
        r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign bpu.stat_branches = r_stat_branches;
  assign bpu.stat_mispred  = r_stat_mispred;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// ============================================================================
// Module  : tb_branch_predict_unit
// Brief   : Directed bench for a bimodal (64-entry) and a gshare (8-entry) instance
//           against an operand-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.XLEN(32), .IDX_W(6)) bi ();
  branch_predict_unit_if #(.XLEN(32), .IDX_W(3)) gi ();

  branch_predict_unit #(.BHT_ENTRIES(64), .XLEN(32), .GSHARE(0), .CTR_INIT(2'b01)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .bpu (bi.slave)
  );
  branch_predict_unit #(.BHT_ENTRIES(8), .XLEN(32), .GSHARE(1), .CTR_INIT(2'b01)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bpu (gi.slave)
  );

  // Shared EX operands; flags are derived from rs1 - rs2.
  logic [31:0] op_a = '0, op_b = '0;
  logic [2:0]  f3   = 3'b000;
  logic [31:0] diff;
  logic        zf, sf, cf, vf;
  assign diff = op_a - op_b;
  assign zf   = (diff == 32'd0);
  assign sf   = diff[31];
  assign cf   = (op_a >= op_b);
  assign vf   = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);

  assign bi.zf = zf; assign bi.sf = sf; assign bi.cf = cf; assign bi.vf = vf;
  assign gi.zf = zf; assign gi.sf = sf; assign gi.cf = cf; assign gi.vf = vf;
  assign bi.ex_funct3 = f3;
  assign gi.ex_funct3 = f3;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome from the operands themselves, {legal, taken}.
  function automatic logic [1:0] mcond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0:    return {1'b1, a == b};
      3'd1:    return {1'b1, a != b};
      3'd4:    return {1'b1, $signed(a) <  $signed(b)};
      3'd5:    return {1'b1, $signed(a) >= $signed(b)};
      3'd6:    return {1'b1, a <  b};
      3'd7:    return {1'b1, a >= b};
      default: return 2'b00;
    endcase
  endfunction

  int       m0 [64];
  int       m1 [8];
  int       ghr1;
  int       m_br, m_mp;
  logic [1:0] c0, c1;
  assign c0 = mcond(f3, op_a, op_b);
  assign c1 = c0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m0[i] = 1;
      for (int i = 0; i < 8; i++)  m1[i] = 1;
      ghr1 = 0; m_br = 0; m_mp = 0;
    end else begin
      if (bi.ex_valid && bi.ex_branch && c0[1]) begin
        m0[bi.ex_pred_idx] = c0[0] ? ((m0[bi.ex_pred_idx] < 3) ? m0[bi.ex_pred_idx] + 1 : 3)
                                   : ((m0[bi.ex_pred_idx] > 0) ? m0[bi.ex_pred_idx] - 1 : 0);
        m_br = m_br + 1;
        if (c0[0] != bi.ex_pred_taken) m_mp = m_mp + 1;
      end
      if (gi.ex_valid && gi.ex_branch && c1[1]) begin
        m1[gi.ex_pred_idx] = c1[0] ? ((m1[gi.ex_pred_idx] < 3) ? m1[gi.ex_pred_idx] + 1 : 3)
                                   : ((m1[gi.ex_pred_idx] > 0) ? m1[gi.ex_pred_idx] - 1 : 0);
        ghr1 = ((ghr1 * 2) + (c1[0] ? 1 : 0)) % 8;
      end
    end
  end

  // Compare process: every mid-cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      int idx0, idx1;
      logic l0, l1;
      idx0 = (bi.if_pc / 4) % 64;
      idx1 = ((gi.if_pc / 4) % 8) ^ ghr1;
      l0 = bi.ex_valid && bi.ex_branch && c0[1];
      l1 = gi.ex_valid && gi.ex_branch && c1[1];
      check("d0_idx",   32'(bi.if_pred_idx),   32'(idx0));
      check("d0_pred",  32'(bi.if_pred_taken), 32'(bi.if_valid && m0[idx0] >= 2));
      check("d0_taken", 32'(bi.ex_taken),      32'(l0 && c0[0]));
      check("d0_misp",  32'(bi.ex_mispredict), 32'(l0 && (c0[0] != bi.ex_pred_taken)));
      check("d1_idx",   32'(gi.if_pred_idx),   32'(idx1));
      check("d1_pred",  32'(gi.if_pred_taken), 32'(gi.if_valid && m1[idx1] >= 2));
      check("d1_taken", 32'(gi.ex_taken),      32'(l1 && c1[0]));
      check("d1_misp",  32'(gi.ex_mispredict), 32'(l1 && (c1[0] != gi.ex_pred_taken)));
`ifdef BPU_STATS_EN
      check("stat_br",  bi.stat_branches, 32'(m_br));
      check("stat_mp",  bi.stat_mispred,  32'(m_mp));
`endif
    end
  end

  task automatic ex0(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic pt, input logic [5:0] idx, input logic v);
    @(posedge clk); #2;
    f3 = f; op_a = a; op_b = b;
    bi.ex_valid = v; bi.ex_branch = 1'b1; bi.ex_pred_taken = pt; bi.ex_pred_idx = idx;
    gi.ex_valid = 1'b0;
  endtask

  task automatic ex1(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    f3 = 3'd0; op_a = a; op_b = b;
    gi.ex_valid = 1'b1; gi.ex_branch = 1'b1; gi.ex_pred_taken = 1'b0; gi.ex_pred_idx = 3'd0;
    bi.ex_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #2;
    bi.ex_valid = 1'b0; gi.ex_valid = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3; rst_n = 1'b0;
    #8 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    bi.if_valid = 1'b1; bi.if_pc = 32'h100;
    bi.ex_valid = 1'b0; bi.ex_branch = 1'b0; bi.ex_pred_taken = 1'b0; bi.ex_pred_idx = '0;
    gi.if_valid = 1'b1; gi.if_pc = 32'h0;
    gi.ex_valid = 1'b0; gi.ex_branch = 1'b0; gi.ex_pred_taken = 1'b0; gi.ex_pred_idx = '0;
    #1 rst_n = 1'b0;
    #11 rst_n = 1'b1;

    // 1: reset state
    mid();
    check("t1_pred", 32'(bi.if_pred_taken), 32'd0);
    check("t1_idx",  32'(bi.if_pred_idx),   32'd0);

    // 2: three taken BEQ commits saturate idx 0
    ex0(3'd0, 32'd7, 32'd7, 1'b0, 6'd0, 1'b1);
    ex0(3'd0, 32'd7, 32'd7, 1'b1, 6'd0, 1'b1);
    ex0(3'd0, 32'd7, 32'd7, 1'b1, 6'd0, 1'b1);
    idle(); mid();
    check("t2_pred", 32'(bi.if_pred_taken), 32'd1);
    check("t2_model_ctr", 32'(m0[0]), 32'd3);

    // 3: BLTU taken vs predicted not-taken; then the same slot flushed
    ex0(3'd6, 32'd1, 32'd2, 1'b0, 6'd7, 1'b1);
    mid();
    check("t3_taken", 32'(bi.ex_taken),      32'd1);
    check("t3_misp",  32'(bi.ex_mispredict), 32'd1);
    ex0(3'd6, 32'd1, 32'd2, 1'b0, 6'd9, 1'b0);
    mid();
    check("t3_flush_taken", 32'(bi.ex_taken),      32'd0);
    check("t3_flush_misp",  32'(bi.ex_mispredict), 32'd0);
    bi.if_pc = 32'h24;
    idle(); mid();
    check("t3_idx9_unchanged", 32'(bi.if_pred_taken), 32'd0);

    // illegal funct3 with a live branch: never taken, never trains
    ex0(3'd2, 32'd5, 32'd5, 1'b1, 6'd9, 1'b1);
    mid();
    check("t3_illegal_taken", 32'(bi.ex_taken),      32'd0);
    check("t3_illegal_misp",  32'(bi.ex_mispredict), 32'd0);

    // 4: same-cycle read and train of idx 5
    @(posedge clk); #2;
    bi.if_pc = 32'h114;
    f3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    bi.ex_valid = 1'b1; bi.ex_branch = 1'b1; bi.ex_pred_taken = 1'b0; bi.ex_pred_idx = 6'd5;
    mid();
    check("t4_pred_same_cycle", 32'(bi.if_pred_taken), 32'd0);
    idle(); mid();
    check("t4_pred_next_cycle", 32'(bi.if_pred_taken), 32'd1);

    // mixed signed/unsigned patterns on idx 20, checked by the compare process
    ex0(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 6'd20, 1'b1);
    ex0(3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 6'd20, 1'b1);
    ex0(3'd4, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 6'd20, 1'b1);
    ex0(3'd1, 32'd10, 32'd11, 1'b0, 6'd20, 1'b1);
    ex0(3'd7, 32'h8000_0000, 32'd1, 1'b0, 6'd20, 1'b1);
    ex0(3'd6, 32'hFFFF_FFFF, 32'd0, 1'b1, 6'd20, 1'b1);
    ex0(3'd0, 32'd1, 32'd2, 1'b1, 6'd20, 1'b1);
    ex0(3'd0, 32'd1, 32'd2, 1'b0, 6'd20, 1'b1);
    ex0(3'd0, 32'd1, 32'd2, 1'b0, 6'd20, 1'b1);
    idle(); mid();
    bi.if_pc = 32'd20 * 4;
    mid();
    check("mix_idx20_pred", 32'(bi.if_pred_taken), 32'd0);

    // 5: gshare history 1,0,1
    ex1(32'd4, 32'd4);
    ex1(32'd4, 32'd5);
    ex1(32'd4, 32'd4);
    idle(); mid();
    check("t5_idx_eq_ghr", 32'(gi.if_pred_idx), 32'd5);

    // 6: async reset mid-cycle with trained counters
    ex0(3'd0, 32'd1, 32'd1, 1'b1, 6'd5, 1'b1);
    idle();
    bi.if_pc = 32'h100;
    mid();
    check("t6_pred_before", 32'(bi.if_pred_taken), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_pred_in_reset_idx0", 32'(bi.if_pred_taken), 32'd0);
    bi.if_pc = 32'h114;
    #1;
    check("t6_pred_in_reset_idx5", 32'(bi.if_pred_taken), 32'd0);
    #4 rst_n = 1'b1;
    mid();
    check("t6_pred_after", 32'(bi.if_pred_taken), 32'd0);

`ifdef BPU_STATS_EN
    do_reset();
    for (int k = 0; k < 10; k++) ex0(3'd0, 32'd9, 32'd9, (k < 3) ? 1'b0 : 1'b1, 6'd1, 1'b1);
    idle(); mid();
    check("stats_branches", bi.stat_branches, 32'd10);
    check("stats_mispred",  bi.stat_mispred,  32'd3);
    do_reset();
    mid();
    check("stats_branches_rst", bi.stat_branches, 32'd0);
    check("stats_mispred_rst",  bi.stat_mispred,  32'd0);
`endif

    idle(); mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
